// File: rtl/fifo_pkg.sv
// Shared constants and state type for the FIFO word packer.
// Byte width, packing factor and derived word/counter widths.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int BYTES  = 4;
  localparam int OUT_W  = DATA_W * BYTES;
  localparam int CNT_W  = $clog2(BYTES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LATCH,
    EMIT
  } packer_state_t;

endpackage

// File: rtl/byte_accumulator.sv
// Lane-indexed byte accumulator for the word packer.
// Lanes at or above the used count read back as zero.
module byte_accumulator #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      wr_i,
  input  logic [CNT_W-1:0]          lane_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [CNT_W-1:0]          used_i,
  output logic [DATA_W*BYTES-1:0]   word_o
);

  logic [BYTES-1:0][DATA_W-1:0] acc_q;
  logic [BYTES-1:0][DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (wr_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (lane_i == CNT_W'(k)) begin
          acc_d[k] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (CNT_W'(k) < used_i) begin
        word_o[k*DATA_W +: DATA_W] = acc_q[k];
      end
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a registered-flag FIFO and packs them
// little-endian into words on a valid/ready output.
module fifo_word_packer
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_bytes,
  output logic             busy
);

  packer_state_t    state_q;
  packer_state_t    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             pend_d;
  logic             pend_clr;
  logic             acc_wr;
  logic             acc_clr;
  logic [OUT_W-1:0] word;

  // READ -> LATCH -> IDLE spacing lets the registered empty
  // flag settle before it is sampled again.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_wr   = 1'b0;
    acc_clr  = 1'b0;
    pend_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q && cnt_q != '0) begin
          state_d = EMIT;
        end else if (pend_q) begin
          pend_clr = 1'b1;
        end else if (!fifo_empty) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        acc_wr = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(BYTES)) begin
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          acc_clr  = 1'b1;
          cnt_d    = '0;
          pend_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pend_d = pend_clr ? 1'b0 : (pend_q | flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  byte_accumulator #(
    .DATA_W (DATA_W),
    .BYTES  (BYTES),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk    (clk),
    .rst_i  (reset),
    .clr_i  (acc_clr),
    .wr_i   (acc_wr),
    .lane_i (cnt_q),
    .data_i (fifo_data),
    .used_i (cnt_q),
    .word_o (word)
  );

  assign fifo_rd_en = (state_q == READ);
  assign out_valid  = (state_q == EMIT);
  assign out_data   = out_valid ? word : '0;
  assign out_bytes  = out_valid ? cnt_q : '0;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model, byte-stream
// chunking reference and a per-cycle output checker.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        busy;

  fifo_word_packer dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  fq[$];
  logic [34:0] exp_q[$];
  int          rd_log[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int hs_cyc = 0;
  int underflow = 0;
  logic rnd_mode = 1'b0;
  logic [31:0] m_acc = 32'h0;
  int m_n = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Reference: plain byte stream cut into 4-byte words;
  // a flush emits whatever partial word remains.
  function automatic void model_byte(input logic [7:0] b);
    m_acc = m_acc | (32'(b) << (8 * m_n));
    m_n++;
    if (m_n == 4) begin
      exp_q.push_back({3'd4, m_acc});
      m_acc = 32'h0;
      m_n = 0;
    end
  endfunction

  function automatic void model_flush();
    if (m_n != 0) exp_q.push_back({3'(m_n), m_acc});
    m_acc = 32'h0;
    m_n = 0;
  endfunction

  // FIFO with registered read data and registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() != 0) fifo_data <= fq.pop_front();
      else underflow <= underflow + 1;
    end
    fifo_empty <= (fq.size() == 0);
  end

  logic        prev_rd1 = 1'b0;
  logic        prev_rd2 = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_word = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rd1 = 1'b0;
      prev_rd2 = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (fifo_rd_en) begin
        chk("rd_spacing", {prev_rd1, prev_rd2}, 2'b00);
        chk("rd_during_emit", out_valid, 1'b0);
        rd_cnt++;
        rd_log.push_back(cyc);
      end
      if (prev_stall)
        chk("stall_hold", {out_valid, out_bytes, out_data},
            {1'b1, prev_word});
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0d/%0h want none",
                   out_bytes, out_data);
        end else begin
          chk("word", {out_bytes, out_data}, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word = {out_bytes, out_data};
      prev_rd2 = prev_rd1;
      prev_rd1 = fifo_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    while (fq.size() >= 4 && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) chk("push_timeout", t, 0);
    fq.push_back(b);
    tick();
  endtask

  task automatic wait_fifo_empty(input int lim);
    int t = 0;
    while (fq.size() != 0 && t < lim) begin
      tick();
      t++;
    end
    if (t >= lim) chk("fifo_drain_timeout", t, 0);
  endtask

  task automatic wait_drain(input int lim);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < lim) begin
      tick();
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_rd(input int target, input int lim);
    int t = 0;
    while (rd_cnt < target && t < lim) begin
      tick();
      t++;
    end
    chk("rd_wait", rd_cnt, target);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int r0;
    int h0;
    int n;
    int t;
    int k;
    logic [7:0] b;

    // Reset state and idle with an empty FIFO.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_bytes", out_bytes, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd", fifo_rd_en, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rd", fifo_rd_en, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // Full word, streaming.
    out_ready = 1'b1;
    r0 = rd_cnt;
    h0 = hs_cnt;
    exp_q.push_back({3'd4, 32'h44332211});
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    wait_drain(100);
    chk("full_rd_count", rd_cnt - r0, 4);
    chk("full_hs_count", hs_cnt - h0, 1);
    n = rd_log.size();
    for (int i = 1; i < 4; i++)
      chk("rd_gap", rd_log[n-4+i] - rd_log[n-5+i], 3);

    // Partial word forced out by flush.
    push_byte(8'hAA);
    push_byte(8'hBB);
    wait_fifo_empty(100);
    repeat (4) tick();
    exp_q.push_back({3'd2, 32'h0000BBAA});
    pulse_flush();
    wait_drain(100);
    r0 = rd_cnt;
    h0 = hs_cnt;
    pulse_flush();
    repeat (20) tick();
    chk("no_rd_after_flush", rd_cnt, r0);
    chk("empty_flush_no_word", hs_cnt, h0);

    // Backpressure on a full word, next byte waiting in the FIFO.
    out_ready = 1'b0;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    push_byte(8'h55);
    t = 0;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    chk("stall_valid", out_valid, 1'b1);
    r0 = rd_cnt;
    repeat (10) tick();
    chk("stall_no_rd", rd_cnt, r0);
    chk("stall_fifo_held", fq.size(), 1);
    chk("stall_data", out_data, 32'hA4A3A2A1);
    exp_q.push_back({3'd4, 32'hA4A3A2A1});
    out_ready = 1'b1;
    wait_drain(50);
    h0 = hs_cyc;
    wait_fifo_empty(50);
    chk("pop_after_hs", rd_log[rd_log.size()-1] > h0, 1'b1);
    repeat (4) tick();
    exp_q.push_back({3'd1, 32'h00000055});
    pulse_flush();
    wait_drain(100);

    // Flush arriving while the third byte is latched.
    r0 = rd_cnt;
    h0 = hs_cnt;
    exp_q.push_back({3'd3, 32'h00030201});
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wait_rd(r0 + 3, 100);
    pulse_flush();
    wait_drain(100);
    repeat (10) tick();
    chk("latch_flush_hs", hs_cnt - h0, 1);

    // Reset while the second byte is latched.
    r0 = rd_cnt;
    push_byte(8'h77);
    push_byte(8'h88);
    wait_rd(r0 + 2, 100);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    fq.delete();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    exp_q.push_back({3'd4, 32'hC4C3C2C1});
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    push_byte(8'hC4);
    wait_drain(100);

    // Random bursts, random backpressure, random flushes.
    rnd_mode = 1'b1;
    m_acc = 32'h0;
    m_n = 0;
    for (int bu = 0; bu < 25; bu++) begin
      k = $urandom_range(1, 9);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        model_byte(b);
        push_byte(b);
      end
      wait_fifo_empty(400);
      repeat (4) tick();
      if ($urandom_range(0, 1) == 1) begin
        model_flush();
        pulse_flush();
      end
    end
    model_flush();
    pulse_flush();
    wait_drain(800);
    rnd_mode = 1'b0;

    chk("fifo_underflow", underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
